// File: rtl/kbd_uart_arbiter_pkg.sv
// Shared types for the keyboard/host UART arbiter: FSM state encoding,
// requester identifiers and the round-robin pick helper.
package kbd_uart_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WAIT_START = 2'd1,
        WAIT_DONE  = 2'd2
    } arb_state_t;

    localparam logic REQ_KBD  = 1'b0;
    localparam logic REQ_HOST = 1'b1;

    // On a tie the requester that was not served last wins; a lone requester always wins.
    function automatic logic pick_requester(input logic kbd_pend,
                                            input logic host_pend,
                                            input logic last_served);
        if (kbd_pend && host_pend) begin
            return ~last_served;
        end else if (host_pend) begin
            return REQ_HOST;
        end else begin
            return REQ_KBD;
        end
    endfunction

endpackage

// File: rtl/scancode_fifo.sv
// Small 8-bit scancode FIFO with combinational head read. A push into a full
// FIFO is accepted only when a pop happens in the same cycle.
module scancode_fifo #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic       pop,
    input  logic [7:0] din,
    output logic [7:0] dout,
    output logic       full,
    output logic       empty,
    output logic [4:0] count
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [4:0]    r_count;
    logic          w_do_push;
    logic          w_do_pop;

    assign empty     = (r_count == 5'd0);
    assign full      = (r_count == 5'(DEPTH));
    assign w_do_pop  = pop && !empty;
    assign w_do_push = push && (!full || w_do_pop);
    assign dout      = r_mem[r_rd_ptr];
    assign count     = r_count;

    // Storage carries no reset; only the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    // DEPTH is a power of two, so the pointers wrap by natural overflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= 5'd0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 5'd1;
                2'b01:   r_count <= r_count - 5'd1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/kbd_uart_arbiter.sv
// Arbitrates a buffered PS/2 scancode stream and a host byte source onto one
// UART transmitter, with round-robin selection and a start-handshake timeout.
module kbd_uart_arbiter
    import kbd_uart_arbiter_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int START_TMO  = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       kbd_valid,
    input  logic [7:0] kbd_code,
    input  logic       kbd_perr,
    input  logic       host_req,
    input  logic [7:0] host_data,
    output logic       host_gnt,
    input  logic       tx_busy,
    output logic       tx_load,
    output logic [7:0] tx_data,
    output logic       ovf,
    output logic       tmo,
    output logic [4:0] fifo_cnt
);
    arb_state_t r_state;
    arb_state_t w_state_next;
    logic [3:0] r_tmo_cnt;
    logic       r_armed;
    logic       r_last;
    logic       r_tx_load;
    logic       r_host_gnt;
    logic [7:0] r_tx_data;
    logic       r_ovf;
    logic       r_tmo;

    logic       w_push;
    logic       w_fifo_full;
    logic       w_fifo_empty;
    logic [7:0] w_fifo_head;
    logic [4:0] w_fifo_cnt;
    logic       w_launch;
    logic       w_timeout;
    logic       w_sel;
    logic       w_grant_kbd;
    logic       w_grant_host;
    logic [7:0] w_load_data;

    assign w_push = kbd_valid && !kbd_perr;

    scancode_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_push),
        .pop   (w_grant_kbd),
        .din   (kbd_code),
        .dout  (w_fifo_head),
        .full  (w_fifo_full),
        .empty (w_fifo_empty),
        .count (w_fifo_cnt)
    );

    // r_armed holds off the first grant until the second edge after reset.
    assign w_launch  = (r_state == IDLE) && r_armed && !tx_busy &&
                       (!w_fifo_empty || host_req);
    assign w_timeout = (r_state == WAIT_START) && !tx_busy &&
                       (r_tmo_cnt == 4'(START_TMO - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:       if (w_launch)  w_state_next = WAIT_START;
            WAIT_START: if (tx_busy)   w_state_next = WAIT_DONE;
                        else if (w_timeout) w_state_next = IDLE;
            WAIT_DONE:  if (!tx_busy)  w_state_next = IDLE;
            default:    w_state_next = IDLE;
        endcase
    end

    always_comb begin
        w_sel        = pick_requester(!w_fifo_empty, host_req, r_last);
        w_grant_kbd  = w_launch && (w_sel == REQ_KBD);
        w_grant_host = w_launch && (w_sel == REQ_HOST);
        w_load_data  = (w_sel == REQ_HOST) ? host_data : w_fifo_head;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tx_load  <= 1'b0;
            r_host_gnt <= 1'b0;
            r_tx_data  <= 8'h00;
            r_last     <= REQ_HOST;
            r_ovf      <= 1'b0;
            r_tmo      <= 1'b0;
            r_armed    <= 1'b0;
            r_tmo_cnt  <= 4'd0;
        end else begin
            r_tx_load  <= w_launch;
            r_host_gnt <= w_grant_host;
            r_armed    <= 1'b1;
            if (w_launch) begin
                r_tx_data <= w_load_data;
                r_last    <= w_sel;
            end
            // A keyboard grant frees a slot in the same cycle, so that push survives.
            if (w_push && w_fifo_full && !w_grant_kbd) begin
                r_ovf <= 1'b1;
            end
            if (w_timeout) begin
                r_tmo <= 1'b1;
            end
            if ((r_state == WAIT_START) && !tx_busy) begin
                r_tmo_cnt <= r_tmo_cnt + 4'd1;
            end else begin
                r_tmo_cnt <= 4'd0;
            end
        end
    end

    assign tx_load  = r_tx_load;
    assign host_gnt = r_host_gnt;
    assign tx_data  = r_tx_data;
    assign ovf      = r_ovf;
    assign tmo      = r_tmo;
    assign fifo_cnt = w_fifo_cnt;

endmodule

// File: tb/tb_kbd_uart_arbiter.sv
// Self-checking bench for kbd_uart_arbiter: a queue-based transaction model
// checked every cycle, plus directed scenarios with literal expectations.
module tb_kbd_uart_arbiter;
    localparam int DEPTH = 4;
    localparam int TMO   = 15;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       kbd_valid = 1'b0;
    logic [7:0] kbd_code = 8'h00;
    logic       kbd_perr = 1'b0;
    logic       host_req = 1'b0;
    logic [7:0] host_data = 8'h00;
    logic       host_gnt;
    logic       tx_busy = 1'b0;
    logic       tx_load;
    logic [7:0] tx_data;
    logic       ovf;
    logic       tmo;
    logic [4:0] fifo_cnt;

    always #5 clk = ~clk;

    kbd_uart_arbiter #(
        .FIFO_DEPTH (DEPTH),
        .START_TMO  (TMO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .kbd_valid (kbd_valid),
        .kbd_code  (kbd_code),
        .kbd_perr  (kbd_perr),
        .host_req  (host_req),
        .host_data (host_data),
        .host_gnt  (host_gnt),
        .tx_busy   (tx_busy),
        .tx_load   (tx_load),
        .tx_data   (tx_data),
        .ovf       (ovf),
        .tmo       (tmo),
        .fifo_cnt  (fifo_cnt)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // UART model: mode 0 = busy for busy_len cycles starting one cycle after a load,
    // mode 1 = busy stuck low, mode 2 = busy stuck high.
    int uart_mode = 0;
    int busy_len  = 6;
    int uart_left = 0;
    bit uart_pend = 0;
    always @(posedge clk) begin
        #1;
        if (uart_mode == 2) begin
            tx_busy = 1'b1;
        end else if (uart_mode == 1) begin
            tx_busy = 1'b0;
        end else begin
            if (uart_pend) begin
                uart_left = busy_len;
                uart_pend = 0;
            end else if (uart_left > 0) begin
                uart_left--;
            end
            tx_busy = (uart_left > 0);
            if (tx_load) uart_pend = 1;
        end
    end

    // Host agent: presents queued bytes one at a time, drops the request on grant.
    logic [7:0] host_q[$];
    always @(posedge clk) begin
        #1;
        if (host_gnt) begin
            host_req = 1'b0;
        end else if (!host_req && host_q.size() > 0) begin
            host_data = host_q.pop_front();
            host_req  = 1'b1;
        end
    end

    // Transaction model: a queue of scancodes, a "transmitter free" flag and the rules
    // for launching, start timeout, round-robin choice and overflow.
    logic [7:0] m_q[$];
    bit         m_last_host = 1, m_ovf = 0, m_tmo = 0, m_free = 1, m_wait_busy = 0, m_armed = 0;
    int         m_wait = 0;
    bit         m_load = 0, m_gnt = 0;
    logic [7:0] m_data = 8'h00;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_q.delete();
            m_last_host = 1; m_ovf = 0; m_tmo = 0; m_free = 1; m_wait_busy = 0;
            m_armed = 0; m_wait = 0; m_load = 0; m_gnt = 0; m_data = 8'h00;
        end else begin
            bit take_host;
            m_load = 0;
            m_gnt  = 0;
            if (m_free) begin
                if (m_armed && !tx_busy && (m_q.size() > 0 || host_req)) begin
                    take_host = host_req && (m_q.size() == 0 || !m_last_host);
                    if (take_host) begin
                        m_data = host_data;
                        m_gnt  = 1;
                    end else begin
                        m_data = m_q.pop_front();
                    end
                    m_last_host = take_host;
                    m_load = 1; m_free = 0; m_wait_busy = 1; m_wait = 0;
                end
            end else if (m_wait_busy) begin
                if (tx_busy) begin
                    m_wait_busy = 0;
                end else begin
                    m_wait++;
                    if (m_wait == TMO) begin
                        m_tmo = 1; m_wait_busy = 0; m_free = 1;
                    end
                end
            end else if (!tx_busy) begin
                m_free = 1;
            end
            if (kbd_valid && !kbd_perr) begin
                if (m_q.size() < DEPTH) m_q.push_back(kbd_code);
                else m_ovf = 1;
            end
            m_armed = 1;
        end
    end

    logic [7:0] tx_log[$];
    int         gnt_seen = 0;
    always @(negedge clk) begin
        if (!rst) begin
            chk("tx_load",  tx_load,  m_load);
            chk("host_gnt", host_gnt, m_gnt);
            chk("tx_data",  tx_data,  m_data);
            chk("ovf",      ovf,      m_ovf);
            chk("tmo",      tmo,      m_tmo);
            chk("fifo_cnt", fifo_cnt, m_q.size());
            if (tx_load)  tx_log.push_back(tx_data);
            if (host_gnt) gnt_seen++;
        end
    end

    task automatic kbd_send(input logic [7:0] code, input logic perr);
        @(posedge clk); #1;
        kbd_valid = 1'b1; kbd_code = code; kbd_perr = perr;
        @(posedge clk); #1;
        kbd_valid = 1'b0; kbd_perr = 1'b0;
    endtask

    task automatic do_reset(input string name);
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        chk({name, "_rst_tx_load"},  tx_load,  0);
        chk({name, "_rst_host_gnt"}, host_gnt, 0);
        chk({name, "_rst_tx_data"},  tx_data,  8'h00);
        chk({name, "_rst_ovf"},      ovf,      0);
        chk({name, "_rst_tmo"},      tmo,      0);
        chk({name, "_rst_fifo_cnt"}, fifo_cnt, 0);
        @(posedge clk); #3;
        rst = 1'b0;
    endtask

    task automatic wait_quiet(input string name);
        int n = 0;
        while (!(m_free && m_q.size() == 0 && host_q.size() == 0 && !host_req &&
                 !tx_busy && !uart_pend && !kbd_valid) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_settled"}, (n < 3000), 1);
        repeat (2) @(negedge clk);
    endtask

    logic [7:0] exp_q[$];
    task automatic check_log(input string name, input int base);
        logic [31:0] got;
        chk({name, "_nloads"}, tx_log.size() - base, exp_q.size());
        foreach (exp_q[i]) begin
            got = (base + i < tx_log.size()) ? {24'h0, tx_log[base + i]} : 'x;
            chk($sformatf("%s_byte%0d", name, i), got, exp_q[i]);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, actual=running required=done");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int n;

        do_reset("init");
        repeat (3) @(negedge clk);

        // Keyboard only: push at edge 1, tx_load after edge 2.
        busy_len = 100;
        base = tx_log.size();
        @(posedge clk); #1;
        kbd_valid = 1'b1; kbd_code = 8'h53; kbd_perr = 1'b0;
        @(posedge clk); #1;
        kbd_valid = 1'b0;
        @(negedge clk);
        chk("t1_cnt_after_push", fifo_cnt, 1);
        chk("t1_no_load_yet", tx_load, 0);
        @(negedge clk);
        chk("t1_load_latency", tx_load, 1);
        chk("t1_data", tx_data, 8'h53);
        wait_quiet("t1");
        exp_q = '{8'h53};
        check_log("t1", base);
        chk("t1_cnt_final", fifo_cnt, 0);
        busy_len = 6;

        // Parity error: silently dropped.
        base = tx_log.size();
        kbd_send(8'h53, 1'b1);
        repeat (6) @(negedge clk);
        chk("t2_cnt", fifo_cnt, 0);
        chk("t2_nloads", tx_log.size() - base, 0);
        chk("t2_ovf", ovf, 0);

        // Tie after reset: keyboard first, then alternating with host.
        do_reset("t3");
        uart_mode = 2;
        base = tx_log.size();
        n = gnt_seen;
        kbd_send(8'h1C, 1'b0);
        kbd_send(8'h2C, 1'b0);
        host_q.push_back(8'h41);
        host_q.push_back(8'h42);
        repeat (3) @(posedge clk);
        #2 uart_mode = 0;
        wait_quiet("t3");
        exp_q = '{8'h1C, 8'h41, 8'h2C, 8'h42};
        check_log("t3", base);
        chk("t3_gnts", gnt_seen - n, 2);

        // Overflow while the transmitter is held busy.
        uart_mode = 2;
        base = tx_log.size();
        kbd_send(8'h11, 1'b0);
        kbd_send(8'h22, 1'b0);
        kbd_send(8'h33, 1'b0);
        kbd_send(8'h44, 1'b0);
        kbd_send(8'h55, 1'b0);
        @(negedge clk);
        chk("t4_cnt_full", fifo_cnt, 4);
        chk("t4_ovf", ovf, 1);
        uart_mode = 0;
        wait_quiet("t4");
        exp_q = '{8'h11, 8'h22, 8'h33, 8'h44};
        check_log("t4", base);
        chk("t4_ovf_sticky", ovf, 1);

        // Full FIFO with a push in the same cycle as a keyboard grant.
        do_reset("t5");
        uart_mode = 2;
        base = tx_log.size();
        kbd_send(8'hA1, 1'b0);
        kbd_send(8'hA2, 1'b0);
        kbd_send(8'hA3, 1'b0);
        kbd_send(8'hA4, 1'b0);
        @(negedge clk);
        chk("t5_cnt_full", fifo_cnt, 4);
        @(posedge clk); #2;
        uart_mode = 0;
        @(posedge clk); #1;
        kbd_valid = 1'b1; kbd_code = 8'h66; kbd_perr = 1'b0;
        @(posedge clk); #1;
        kbd_valid = 1'b0;
        @(negedge clk);
        chk("t5_load", tx_load, 1);
        chk("t5_load_data", tx_data, 8'hA1);
        chk("t5_cnt_same", fifo_cnt, 4);
        chk("t5_no_ovf", ovf, 0);
        wait_quiet("t5");
        exp_q = '{8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'h66};
        check_log("t5", base);

        // Start timeout: busy never rises.
        uart_mode = 1;
        base = tx_log.size();
        kbd_send(8'h5A, 1'b0);
        n = 0;
        while (!tx_load && n < 50) begin @(negedge clk); n++; end
        n = 0;
        while (!tmo && n < 50) begin @(negedge clk); n++; end
        chk("t6_tmo_after_load", n, 15);
        wait_quiet("t6a");
        kbd_send(8'h3C, 1'b0);
        wait_quiet("t6b");
        exp_q = '{8'h5A, 8'h3C};
        check_log("t6", base);
        chk("t6_tmo_sticky", tmo, 1);

        // Reset during a transmission with two bytes still queued.
        do_reset("t7a");
        uart_mode = 0;
        busy_len = 100;
        kbd_send(8'h01, 1'b0);
        kbd_send(8'h02, 1'b0);
        kbd_send(8'h03, 1'b0);
        n = 0;
        while (!(tx_busy && !m_free && !m_wait_busy) && n < 200) begin @(negedge clk); n++; end
        chk("t7_in_transmit", (n < 200), 1);
        chk("t7_queued", fifo_cnt, 2);
        do_reset("t7b");
        base = tx_log.size();
        repeat (150) @(negedge clk);
        chk("t7_no_load_after_rst", tx_log.size() - base, 0);
        busy_len = 6;
        kbd_send(8'h77, 1'b0);
        wait_quiet("t7");
        exp_q = '{8'h77};
        check_log("t7", base);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
